// File: rtl/arith_pkg.sv
// Shared types and defaults for the arithmetic op scheduler.
// It holds the operation mode, the FSM states, the default widths and the
// divide-by-zero result pattern.
package arith_pkg;

  localparam int DEF_D1_W        = 10;
  localparam int DEF_D2_W        = 3;
  localparam int DEF_RES_W       = 20;
  localparam int DEF_TIMEOUT_CYC = 64;

  typedef enum logic {
    MODE_DIV  = 1'b0,
    MODE_ROOT = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // Result reported for a division whose divisor is zero (default result width).
  localparam logic [DEF_RES_W-1:0] DIV0_RESULT = '1;

  // A division with a zero divisor never reaches the engine.
  function automatic logic is_div0(input logic mode, input logic d2_zero);
    return (mode == MODE_DIV) && d2_zero;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
// The pointer records the requester served last. On a tie the other
// requester wins. The pointer moves only when a grant is actually issued.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output logic       gnt_id
);

  logic ptr_q;

  // Pick the winner: on a tie the requester not served last, otherwise the only valid one
  always_comb begin
    gnt_id = 1'b0;
    if (valid[0] && valid[1]) gnt_id = ~ptr_q;
    else if (valid[1])        gnt_id = 1'b1;
    grant = {en & valid[1] & gnt_id, en & valid[0] & ~gnt_id};
  end

  // Remember who was served so the next tie goes the other way
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                ptr_q <= 1'b0;
    else if (en && (|valid))   ptr_q <= gnt_id;
  end

endmodule

// File: rtl/arith_op_scheduler.sv
// Shares one iterative division/root engine between two requesters.
// Only one op is in flight at a time. The result is held with its requester
// id until the consumer takes it.
// Optional build macro: ARB_TIMEOUT_EN bounds the WAIT state with an abort
// timer. Without it, WAIT is unbounded and eng_abort stays 0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | arbitrate, accept one op, latch operands and id
// ST_ISSUE | single-cycle eng_start pulse
// ST_WAIT  | engine running, wait for eng_done (or the timeout)
// ST_HOLD  | out_valid asserted, out_* frozen until out_ready
module arith_op_scheduler
  import arith_pkg::*;
#(
  parameter int D1_W        = DEF_D1_W,
  parameter int D2_W        = DEF_D2_W,
  parameter int RES_W       = DEF_RES_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_mode,
  input  logic [D1_W-1:0]  req0_data_1,
  input  logic [D2_W-1:0]  req0_data_2,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_mode,
  input  logic [D1_W-1:0]  req1_data_1,
  input  logic [D2_W-1:0]  req1_data_2,
  output logic             eng_start,
  output logic             eng_mode,
  output logic [D1_W-1:0]  eng_data_1,
  output logic [D2_W-1:0]  eng_data_2,
  input  logic             eng_done,
  input  logic [RES_W-1:0] eng_result,
  output logic             eng_abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_id,
  output logic [RES_W-1:0] out_data,
  output logic             out_err,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             arb_en;
  logic [1:0]       grant;
  logic             gnt_id;
  logic             accept;
  logic             sel_mode;
  logic [D1_W-1:0]  sel_d1;
  logic [D2_W-1:0]  sel_d2;
  logic             sel_div0;
  logic             timeout;

  // Gating with rst_n keeps both readies low while reset is held.
  assign arb_en = (state_q == ST_IDLE) && rst_n;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (arb_en),
    .valid  ({req1_valid, req0_valid}),
    .grant  (grant),
    .gnt_id (gnt_id)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;

  assign sel_mode = gnt_id ? req1_mode   : req0_mode;
  assign sel_d1   = gnt_id ? req1_data_1 : req0_data_1;
  assign sel_d2   = gnt_id ? req1_data_2 : req0_data_2;
  assign sel_div0 = is_div0(sel_mode, sel_d2 == '0);

  assign out_valid = (state_q == ST_HOLD);
  assign busy      = (state_q != ST_IDLE);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt_q;

  // Down-counter loaded in ISSUE; reaching zero in WAIT marks the TIMEOUT_CYC-th wait cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     tmo_cnt_q <= '0;
    else if (state_q == ST_ISSUE)                   tmo_cnt_q <= CNT_W'(TIMEOUT_CYC - 1);
    else if (state_q == ST_WAIT && tmo_cnt_q != '0) tmo_cnt_q <= tmo_cnt_q - 1'b1;
  end

  assign timeout = (state_q == ST_WAIT) && (tmo_cnt_q == '0);
`else
  // No abort timer in this build; WAIT lasts until eng_done.
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state plus the start/abort pulses; eng_done beats a same-cycle timeout
  always_comb begin
    state_d   = state_q;
    eng_start = 1'b0;
    eng_abort = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = sel_div0 ? ST_HOLD : ST_ISSUE;
      end
      ST_ISSUE: begin
        eng_start = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (eng_done) begin
          state_d = ST_HOLD;
        end else if (timeout) begin
          eng_abort = 1'b1;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand/id capture on accept and result capture at the end of WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_mode   <= 1'b0;
      eng_data_1 <= '0;
      eng_data_2 <= '0;
      out_id     <= 1'b0;
      out_data   <= '0;
      out_err    <= 1'b0;
    end else if (accept) begin
      eng_mode   <= sel_mode;
      eng_data_1 <= sel_d1;
      eng_data_2 <= sel_d2;
      out_id     <= gnt_id;
      if (sel_div0) begin
        out_data <= {RES_W{1'b1}};
        out_err  <= 1'b1;
      end
    end else if (state_q == ST_WAIT) begin
      if (eng_done) begin
        out_data <= eng_result;
        out_err  <= 1'b0;
      end else if (timeout) begin
        out_data <= '0;
        out_err  <= 1'b1;
      end
    end
  end

endmodule
